// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_write_arbiter_pkg                                        |
// | Purpose  : Shared definitions for the FIFO write-port arbiter: FSM state |
// |            encoding and a constant-width helper.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fifo_write_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 bit, for sizing index/counter vectors.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_write_arbiter_if                                         |
// | Purpose  : Bundles the producer request/data bus and the FIFO write pins |
// |            around the arbiter.                                           |
// | Signals  : req, wdata_in, fifo_full      -> into the arbiter             |
// |            gnt, fifo_shift_in, fifo_wdata,                               |
// |            owner, busy                   <- from the arbiter             |
// | Modports : master = arbiter side, slave = producers/FIFO side            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  import fifo_write_arbiter_pkg::*;

  localparam int OWNER_W = clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata_in;
  logic [N_REQ-1:0]       gnt;
  logic                   fifo_full;
  logic                   fifo_shift_in;
  logic [WIDTH-1:0]       fifo_wdata;
  logic [OWNER_W-1:0]     owner;
  logic                   busy;

  modport master (
    input  req, wdata_in, fifo_full,
    output gnt, fifo_shift_in, fifo_wdata, owner, busy
  );

  modport slave (
    output req, wdata_in, fifo_full,
    input  gnt, fifo_shift_in, fifo_wdata, owner, busy
  );

endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick                                                       |
// | Purpose  : Combinational round-robin picker. Returns the first set       |
// |            request index at or after i_ptr, wrapping modulo N_REQ.       |
// | Ports    : i_req   [N_REQ]  request vector                               |
// |            i_ptr   [PW]     search start index                           |
// |            o_idx   [PW]     selected index (valid only with o_valid)     |
// |            o_valid          at least one request set                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [PW-1:0]    o_idx,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_rot;
  logic [PW:0]      w_j;
  logic [PW-1:0]    w_p;
  logic [PW:0]      w_sum;

  // Rotate so that i_ptr lands on bit 0, pick the lowest set bit, then
  // add i_ptr back. Wrap is an explicit compare-subtract so non power of
  // two requester counts stay correct.
  always_comb begin
    w_rot = '0;
    w_j   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = {1'b0, PW'(i)} + {1'b0, i_ptr};
      if (w_j >= (PW+1)'(N_REQ)) w_j = w_j - (PW+1)'(N_REQ);
      w_rot[i] = i_req[w_j[PW-1:0]];
    end

    w_p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_p = PW'(i);
    end

    w_sum = {1'b0, w_p} + {1'b0, i_ptr};
    if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
  end

  assign o_idx   = w_sum[PW-1:0];
  assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_write_arbiter                                            |
// | Purpose  : Round-robin sharing of one FIFO write port among N_REQ        |
// |            producers. An owner keeps the port for up to MAX_BURST words, |
// |            then ownership rotates. FIFO strobe/data are registered.      |
// | Ports    : clk    clock                                                  |
// |            res_n  asynchronous active-low reset                          |
// |            bus    fifo_write_arbiter_if.master (req, wdata_in, gnt,      |
// |                   fifo_full, fifo_shift_in, fifo_wdata, owner, busy)     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  res_n,
  fifo_write_arbiter_if.master  bus
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_shift;
  logic [WIDTH-1:0]   r_wdata;

  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_owner_req;
  logic               w_accept;
  logic               w_last;
  logic               w_leave;
  logic [PTR_W-1:0]   w_owner_inc;
  logic [N_REQ-1:0]   w_gnt;
  logic [WIDTH-1:0]   w_slice;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PTR_W)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_accept    = (r_state == ST_BURST) && w_owner_req && !bus.fifo_full;
  assign w_last      = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt[i] = w_accept && (r_owner == PTR_W'(i));
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == PTR_W'(i)) w_slice = bus.wdata_in[i*WIDTH +: WIDTH];
    end
  end

  // Next state. A full FIFO only freezes the burst; losing the owner's
  // request or taking the last word of the burst ends it.
  always_comb begin
    w_state_nxt = r_state;
    w_leave     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (!w_owner_req || (w_accept && w_last)) begin
          w_state_nxt = ST_IDLE;
          w_leave     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_shift <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_shift <= w_accept;
      if (w_accept) begin
        r_wdata <= w_slice;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_IDLE) && w_pick_valid) begin
        r_owner <= w_pick_idx;
        r_cnt   <= '0;
      end
      if (w_leave) r_ptr <= w_owner_inc;
    end
  end

  assign bus.gnt           = w_gnt;
  assign bus.fifo_shift_in = r_shift;
  assign bus.fifo_wdata    = r_wdata;
  assign bus.owner         = r_owner;
  assign bus.busy          = (r_state == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_write_arbiter                                         |
// | Purpose  : Self-checking bench for fifo_write_arbiter with a behavioural |
// |            ownership model, producer word counters and an early-full     |
// |            FIFO occupancy model.                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic res_n;
  logic res2_n;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) b ();
  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) b2 ();

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk (clk), .res_n (res_n), .bus (b)
  );

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(1)) dut2 (
    .clk (clk), .res_n (res2_n), .bus (b2)
  );

  int tests = 0;
  int fails = 0;

  // Producer word numbers; slice i = 8'h10*i + word#.
  int wcnt [N];

  // Reference model: who owns the port, how many words taken this ownership,
  // where the next search starts, and what the registered write stage holds.
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_cnt;
  bit         m_shift;
  logic [7:0] m_wdata;
  logic [N-1:0] last_gnt;

  function automatic logic [7:0] slice_of(input int i);
    return 8'(16 * i + wcnt[i]);
  endfunction

  task automatic apply_wdata();
    for (int i = 0; i < N; i++) b.wdata_in[i*W +: W] = slice_of(i);
  endtask

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_busy && b.req[m_owner[1:0]] && !b.fifo_full) g = N'(1) << m_owner;
    return g;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_shift = 0; m_wdata = '0;
  endtask

  task automatic model_clock();
    bit acc;
    bit found;
    int idx;
    acc     = (m_gnt() != '0);
    m_shift = acc;
    if (acc) m_wdata = slice_of(m_owner);
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && b.req[idx[1:0]]) begin
          found = 1; m_owner = idx;
        end
      end
      if (found) begin m_busy = 1; m_cnt = 0; end
    end else begin
      if (acc) m_cnt++;
      if (!b.req[m_owner[1:0]] || (acc && m_cnt == MB)) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  // One clock: sample at negedge, advance model, step producers after the edge.
  // Packed layout: {gnt[15:12], busy[11], owner[10:9], shift[8], wdata[7:0]}
  task automatic tick(output logic [15:0] o, output logic [15:0] e);
    @(negedge clk);
    o = {b.gnt, b.busy, b.owner, b.fifo_shift_in, b.fifo_wdata};
    e = {m_gnt(), m_busy, 2'(m_owner), m_shift, m_wdata};
    last_gnt = b.gnt;
    model_clock();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_gnt[i]) wcnt[i]++;
    apply_wdata();
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    res_n = 1'b0;
    b.req = r;
    b.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    apply_wdata();
    @(posedge clk);
    #1;
    m_reset();
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] o, e;
    res_n = 1'b0;
    b.req = 4'hF;
    b.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    apply_wdata();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (b.gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0000", b.gnt); end
    tests++; if (b.fifo_shift_in !== 1'b0) begin fails++; $display("FAIL reset_shift: got %b want 0", b.fifo_shift_in); end
    tests++; if (b.fifo_wdata !== 8'h00) begin fails++; $display("FAIL reset_wdata: got %h want 00", b.fifo_wdata); end
    tests++; if (b.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", b.busy); end
    @(posedge clk);
    #1;
    m_reset();
    res_n = 1'b1;
    tick(o, e);
    tests++; if (o[15:12] !== 4'b0000) begin fails++; $display("FAIL reset_bubble: gnt got %b want 0000", o[15:12]); end
    tick(o, e);
    tests++; if ({o[15:12], o[10:9]} !== {4'b0001, 2'd0}) begin
      fails++; $display("FAIL reset_first_gnt: gnt/owner got %b/%0d want 0001/0", o[15:12], o[10:9]);
    end
  endtask

  task automatic test_bursts();
    logic [15:0] o, e;
    int q[$];
    do_reset(4'hF);
    for (int c = 0; c < 22; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL bursts cyc%0d: got %h want %h", c, o, e); end
      if (o[15:12] != 4'b0) q.push_back($clog2(o[15:12]));
    end
    tests++; if (q.size() != 17) begin fails++; $display("FAIL bursts_count: got %0d want 17", q.size()); end
    for (int k = 0; k < q.size() && k < 17; k++) begin
      tests++;
      if (q[k] != ((k < 16) ? k / 4 : 0)) begin
        fails++; $display("FAIL bursts_seq[%0d]: got %0d want %0d", k, q[k], (k < 16) ? k / 4 : 0);
      end
    end
  endtask

  task automatic test_early_release();
    logic [15:0] o, e;
    int acc;
    do_reset(4'b0100);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL early cyc%0d: got %h want %h", c, o, e); end
      if (o[15:12] == 4'b0100) acc++;
      if (acc == 2) b.req = 4'b0000;
    end
    tests++; if (o[11] !== 1'b0) begin fails++; $display("FAIL early_busy: got %b want 0", o[11]); end
    b.req = 4'b0010;
    tick(o, e);
    tick(o, e);
    tests++; if ({o[15:12], o[10:9]} !== {4'b0010, 2'd1}) begin
      fails++; $display("FAIL early_wrap: gnt/owner got %b/%0d want 0010/1", o[15:12], o[10:9]);
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] o, e;
    int acc, n0;
    bit rot;
    do_reset(4'hF);
    acc = 0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL stall_pre cyc%0d: got %h want %h", c, o, e); end
      if (o[15:12] == 4'b0001) acc++;
    end
    b.fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL stall cyc%0d: got %h want %h", c, o, e); end
      tests++; if ({o[15:12], o[10:9], (c > 0) ? o[8] : 1'b0} !== 7'b0) begin
        fails++; $display("FAIL stall_hold cyc%0d: gnt/owner/shift got %b/%0d/%b want 0000/0/0", c, o[15:12], o[10:9], o[8]);
      end
    end
    b.fifo_full = 1'b0;
    n0 = 0; rot = 0;
    for (int c = 0; c < 8 && !rot; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL stall_post cyc%0d: got %h want %h", c, o, e); end
      if (o[15:12] == 4'b0001) n0++;
      if (o[15:12] == 4'b0010) rot = 1;
    end
    tests++; if (n0 != 2 || !rot) begin fails++; $display("FAIL stall_resume: words %0d rotated %0d want 2 1", n0, rot); end
  endtask

  task automatic test_async_reset();
    logic [15:0] o, e;
    bit seen;
    do_reset(4'hF);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL areset_pre cyc%0d: got %h want %h", c, o, e); end
      if (o[15:12] == 4'b0010) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL areset_owner1: no gnt from 1 within 20 cycles"); end
    tests++; if (b.fifo_shift_in !== 1'b1) begin fails++; $display("FAIL areset_inflight: shift got %b want 1", b.fifo_shift_in); end
    #2;
    res_n = 1'b0;
    #1;
    tests++; if ({b.fifo_shift_in, b.busy} !== 2'b00) begin
      fails++; $display("FAIL areset_immediate: shift/busy got %b%b want 00", b.fifo_shift_in, b.busy);
    end
    @(posedge clk);
    #1;
    tests++; if (b.fifo_shift_in !== 1'b0) begin fails++; $display("FAIL areset_nowrite: shift got %b want 0", b.fifo_shift_in); end
    m_reset();
    res_n = 1'b1;
    tick(o, e);
    tick(o, e);
    tests++; if (o !== e || o[15:12] !== 4'b0001) begin
      fails++; $display("FAIL areset_ptr: got %h want %h (gnt 0001)", o, e);
    end
  endtask

  task automatic test_random();
    logic [15:0] o, e;
    int fcnt;
    do_reset(4'b0000);
    fcnt = 0;
    for (int c = 0; c < 400; c++) begin
      b.fifo_full = (fcnt >= DEPTH - 1);
      tick(o, e);
      tests++; if (o !== e) begin fails++; $display("FAIL random cyc%0d: got %h want %h", c, o, e); end
      if (o[8]) begin
        fcnt++;
        tests++; if (fcnt > DEPTH) begin fails++; $display("FAIL random_overflow cyc%0d: level %0d max %0d", c, fcnt, DEPTH); end
      end
      if (fcnt > 0 && $urandom_range(0, 2) == 0) fcnt--;
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i])   b.req[i] = ($urandom_range(0, 3) != 0);
        else if (b.req[i]) b.req[i] = ($urandom_range(0, 7) != 0);
        else               b.req[i] = ($urandom_range(0, 2) == 0);
      end
    end
  endtask

  task automatic test_max_burst1();
    logic [3:0] exp_g [8];
    logic [3:0] prev;
    exp_g = '{4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0, 4'h8};
    b2.req = 4'b1010;
    b2.wdata_in = {8'h31, 8'h21, 8'h11, 8'h01};
    b2.fifo_full = 1'b0;
    @(posedge clk);
    #1;
    res2_n = 1'b1;
    prev = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++; if (b2.gnt !== exp_g[k]) begin fails++; $display("FAIL mb1_gnt[%0d]: got %b want %b", k, b2.gnt, exp_g[k]); end
      tests++;
      if ({b2.fifo_shift_in, (prev != 0) ? b2.fifo_wdata : 8'h00} !==
          {prev != 4'h0, (prev == 4'h2) ? 8'h11 : (prev == 4'h8) ? 8'h31 : 8'h00}) begin
        fails++; $display("FAIL mb1_write[%0d]: shift/wdata got %b/%h after gnt %b", k, b2.fifo_shift_in, b2.fifo_wdata, prev);
      end
      prev = exp_g[k];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    res_n = 1'b0;
    res2_n = 1'b0;
    b.req = '0;
    b.fifo_full = 1'b0;
    b.wdata_in = '0;
    b2.req = '0;
    b2.fifo_full = 1'b0;
    b2.wdata_in = '0;
    m_reset();
    last_gnt = '0;
    test_reset();
    test_bursts();
    test_early_release();
    test_full_stall();
    test_async_reset();
    test_random();
    test_max_burst1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
